// File: rtl/seq_det_arbiter_pkg.sv
// Shared encodings for the time-shared "101" detector arbiter.
package seq_det_arbiter_pkg;

  // Detector core states; the value is the per-channel saved context.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } core_state_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STORE = 2'b10
  } fsm_state_t;

  // Overlapped "101" transition function.
  function automatic core_state_t core_next(input core_state_t cur, input logic bit_in);
    case (cur)
      S0:      core_next = bit_in ? S1 : S0;
      S1:      core_next = bit_in ? S1 : S2;
      S2:      core_next = bit_in ? S3 : S0;
      default: core_next = bit_in ? S1 : S2;
    endcase
  endfunction

endpackage

// File: rtl/seq101_core.sv
// Moore "101" overlapped detector; load replaces the state, otherwise one bit per cycle.
module seq101_core
  import seq_det_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_state,
  input  logic       in,
  output logic [1:0] state,
  output logic       out
);

  core_state_t state_q;

  // Load a saved context or advance on the incoming bit.
  always_ff @(posedge clk) begin
    if (rst)       state_q <= S0;
    else if (load) state_q <= core_state_t'(load_state);
    else           state_q <= core_next(state_q, in);
  end

  assign state = state_q;
  assign out   = (state_q == S3);

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that time-shares one "101" detector among NCH serial channels.
//
// state | meaning
// IDLE  | waiting; grants first requester at/after rr_q, loads its context
// SHIFT | feeds the latched word MSB first, W cycles
// STORE | writes detector state back to the granted channel's context
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] data,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   ack,
  output logic             match,
  output logic [1:0]       match_ch,
  output logic [15:0]      match_cnt,
  output logic             busy
);

  localparam int CW = 2;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  fsm_state_t    state_q, state_d;
  logic [CW-1:0] rr_q, ch_q, grant_id, scan_idx;
  logic          grant_vld;
  logic [W-1:0]  word_q, grant_word;
  logic [BW-1:0] cnt_q;
  core_state_t   ctx_q [NCH];
  logic [1:0]    core_state, core_load_state;
  logic          core_out, core_load, core_in;
  // High when the core advanced on the previous edge, so a freshly loaded S3 is not re-reported.
  logic          shifted_q;

  seq101_core u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .load_state (core_load_state),
    .in         (core_in),
    .state      (core_state),
    .out        (core_out)
  );

  // Round-robin scan: first requester at or after rr_q (index wraps with CW bits).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = rr_q + CW'(i);
      if (!grant_vld && req[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  // Select the granted channel's word.
  always_comb begin
    grant_word = '0;
    for (int c = 0; c < NCH; c++)
      if (grant_id == CW'(c)) grant_word = data[c*W +: W];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = STORE;
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ack, core control, busy and match qualification.
  always_comb begin
    ack             = '0;
    core_load       = 1'b1;
    core_load_state = core_state;
    core_in         = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          ack[grant_id]   = 1'b1;
          core_load_state = ctx_q[grant_id];
        end
      end
      SHIFT: begin
        core_load = 1'b0;
        core_in   = word_q[cnt_q];
      end
      default: ;
    endcase
    busy     = (state_q != IDLE) || (ack != '0);
    match    = core_out && shifted_q && !rst;
    match_ch = match ? ch_q : '0;
  end

  // Word/channel latch, bit down-counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      ch_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      shifted_q <= 1'b0;
    end else begin
      shifted_q <= (state_q == SHIFT);
      if (state_q == IDLE && grant_vld) begin
        ch_q   <= grant_id;
        word_q <= grant_word;
        cnt_q  <= BW'(W - 1);
      end else if (state_q == SHIFT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == STORE) rr_q <= ch_q + CW'(1);
    end
  end

  // Per-channel context: clear beats the STORE write-back.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || clr[c])
        ctx_q[c] <= S0;
      else if (state_q == STORE && ch_q == CW'(c))
        ctx_q[c] <= core_state_t'(core_state);
    end
  end

  // Saturating match counter.
  always_ff @(posedge clk) begin
    if (rst)                                match_cnt <= '0;
    else if (match && match_cnt != 16'hFFFF) match_cnt <= match_cnt + 16'd1;
  end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Self-checking bench for seq_det_arbiter: directed scenarios plus a randomized run
// against a bit-history reference model.
module tb_seq_det_arbiter;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   req = '0;
  logic [NCH-1:0]   clr = '0;
  logic [NCH*W-1:0] data = '0;
  logic [NCH-1:0]   ack;
  logic             match;
  logic [1:0]       match_ch;
  logic [15:0]      match_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int busy_n = 0;
  int ack_bad = 0;
  int first_c;
  int ack_ch_q[$];
  int ack_t_q[$];
  int m_ch_q[$];
  int m_t_q[$];

  seq_det_arbiter #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .clr       (clr),
    .ack       (ack),
    .match     (match),
    .match_ch  (match_ch),
    .match_cnt (match_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Event log sampled on the falling edge.
  always @(negedge clk) begin
    cyc_n++;
    if (busy) busy_n++;
    if (ack != '0) begin
      if ($countones(ack) != 1) ack_bad++;
      first_c = -1;
      for (int c = NCH - 1; c >= 0; c--) if (ack[c]) first_c = c;
      ack_ch_q.push_back(first_c);
      ack_t_q.push_back(cyc_n);
    end
    if (match) begin
      m_ch_q.push_back(int'(match_ch));
      m_t_q.push_back(cyc_n);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ack_ch_q.delete(); ack_t_q.delete();
    m_ch_q.delete();   m_t_q.delete();
    busy_n = 0; ack_bad = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; clr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  // Raise req[c] with word, wait for its grant, drop req right after the granting edge.
  task automatic send(input int c, input logic [W-1:0] word, output int t_ack, output int got_ch);
    int n0;
    bit got;
    n0 = ack_ch_q.size();
    got = 1'b0;
    t_ack = -1;
    got_ch = -1;
    data[c*W +: W] = word;
    req[c] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      if (ack_ch_q.size() > n0) got = 1'b1;
    end
    #1 req[c] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout ch%0d: no ack within 60 cycles, required one", c);
    end else begin
      t_ack  = ack_t_q[ack_t_q.size()-1];
      got_ch = ack_ch_q[ack_ch_q.size()-1];
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: busy still %0b after 60 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; clr = '0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b, expected 0", ack); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b, expected 0", match); end
    checks++; if (match_ch !== 2'd0) begin errors++; $display("FAIL reset_match_ch: got %0d, expected 0", match_ch); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL reset_match_cnt: got %0d, expected 0", match_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b, expected 0", busy); end
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_single();
    int t, ch;
    apply_reset();
    send(0, 8'b1010_1010, t, ch);
    wait_idle();
    checks++; if (ch != 0) begin errors++; $display("FAIL single_ack_ch: got %0d, expected 0", ch); end
    checks++; if (ack_ch_q.size() != 1) begin errors++; $display("FAIL single_ack_count: got %0d, expected 1", ack_ch_q.size()); end
    checks++; if (ack_bad != 0) begin errors++; $display("FAIL single_ack_onehot: got %0d bad cycles, expected 0", ack_bad); end
    checks++; if (busy_n != 10) begin errors++; $display("FAIL single_busy_cycles: got %0d, expected 10", busy_n); end
    checks++; if (m_t_q.size() != 3) begin errors++; $display("FAIL single_match_count: got %0d, expected 3", m_t_q.size()); end
    for (int i = 0; i < m_t_q.size() && i < 3; i++) begin
      checks++;
      if (m_t_q[i] != t + 4 + 2*i || m_ch_q[i] != 0) begin
        errors++;
        $display("FAIL single_match%0d: got t+%0d ch%0d, expected t+%0d ch0", i, m_t_q[i]-t, m_ch_q[i], 4+2*i);
      end
    end
    checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL single_match_cnt: got %0d, expected 3", match_cnt); end
  endtask

  task automatic test_cross_word();
    int t, ch;
    apply_reset();
    send(1, 8'b0000_0010, t, ch);
    wait_idle();
    checks++; if (m_t_q.size() != 0) begin errors++; $display("FAIL cross_word1_matches: got %0d, expected 0", m_t_q.size()); end
    send(1, 8'b1000_0000, t, ch);
    wait_idle();
    checks++; if (m_t_q.size() != 1) begin errors++; $display("FAIL cross_word2_matches: got %0d, expected 1", m_t_q.size()); end
    else begin
      checks++;
      if (m_t_q[0] != t + 2 || m_ch_q[0] != 1) begin
        errors++;
        $display("FAIL cross_match_pos: got t+%0d ch%0d, expected t+2 ch1", m_t_q[0]-t, m_ch_q[0]);
      end
    end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL cross_match_cnt: got %0d, expected 1", match_cnt); end
  endtask

  task automatic test_isolation();
    int t, ch;
    apply_reset();
    send(1, 8'b0000_0010, t, ch);
    wait_idle();
    send(2, 8'b1000_0000, t, ch);
    wait_idle();
    checks++; if (ch != 2) begin errors++; $display("FAIL iso_ack_ch: got %0d, expected 2", ch); end
    checks++; if (m_t_q.size() != 0) begin errors++; $display("FAIL iso_ch2_matches: got %0d, expected 0", m_t_q.size()); end
    send(1, 8'b1000_0000, t, ch);
    wait_idle();
    checks++; if (m_t_q.size() != 1) begin errors++; $display("FAIL iso_ch1_matches: got %0d, expected 1", m_t_q.size()); end
    else begin
      checks++; if (m_ch_q[0] != 1) begin errors++; $display("FAIL iso_match_ch: got %0d, expected 1", m_ch_q[0]); end
    end
  endtask

  task automatic test_round_robin();
    bit got;
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    data = '0;
    req = '1;
    got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(posedge clk);
      if (ack_ch_q.size() >= 5) got = 1'b1;
    end
    #1 req = '0;
    wait_idle();
    checks++; if (ack_ch_q.size() != 5) begin errors++; $display("FAIL rr_ack_count: got %0d, expected 5", ack_ch_q.size()); end
    for (int i = 0; i < ack_ch_q.size() && i < 5; i++) begin
      checks++;
      if (ack_ch_q[i] != exp_ch[i]) begin errors++; $display("FAIL rr_order%0d: got ch%0d, expected ch%0d", i, ack_ch_q[i], exp_ch[i]); end
      if (i > 0) begin
        checks++;
        if (ack_t_q[i] - ack_t_q[i-1] != 10) begin
          errors++; $display("FAIL rr_spacing%0d: got %0d cycles, expected 10", i, ack_t_q[i] - ack_t_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int t, ch;
    apply_reset();
    send(1, 8'b0000_0010, t, ch);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_store_busy: got %b, expected 1", busy); end
    clr[1] = 1'b1;
    @(posedge clk); #1 clr = '0;
    wait_idle();
    send(1, 8'b1000_0000, t, ch);
    wait_idle();
    checks++; if (m_t_q.size() != 0) begin errors++; $display("FAIL clr_wins_matches: got %0d, expected 0", m_t_q.size()); end
    // clr of the channel in service must not disturb the running core.
    send(0, 8'b1010_0000, t, ch);
    @(posedge clk); #1 clr[0] = 1'b1;
    @(posedge clk); #1 clr = '0;
    wait_idle();
    checks++; if (m_t_q.size() != 1) begin errors++; $display("FAIL clr_active_matches: got %0d, expected 1", m_t_q.size()); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL clr_match_cnt: got %0d, expected 1", match_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    int t, ch, n0;
    bit got;
    apply_reset();
    send(0, 8'b0000_0010, t, ch);
    wait_idle();
    send(1, 8'b1010_1010, t, ch);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy: got %b, expected 0", busy); end
    n0 = ack_ch_q.size();
    data[0*W +: W] = 8'b1000_0000;
    data[1*W +: W] = 8'b0000_0000;
    req = 4'b0011;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk);
      if (ack_ch_q.size() > n0) got = 1'b1;
    end
    #1 req = '0;
    wait_idle();
    checks++;
    if (!got || ack_ch_q.size() != n0 + 1) begin
      errors++; $display("FAIL rst_restart_acks: got %0d new acks, expected 1", ack_ch_q.size() - n0);
    end else begin
      checks++;
      if (ack_ch_q[n0] != 0) begin errors++; $display("FAIL rst_rr_restart: got ch%0d, expected ch0", ack_ch_q[n0]); end
    end
    checks++; if (m_t_q.size() != 0) begin errors++; $display("FAIL rst_matches: got %0d, expected 0", m_t_q.size()); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL rst_match_cnt: got %0d, expected 0", match_cnt); end
  endtask

  // Reference: per-channel bit history since last clear; a match is any "101" ending at a bit.
  task automatic test_random();
    int hist [NCH];
    int hlen [NCH];
    int rr_m, got, t, exp_c, n0;
    int exp_t[$];
    int exp_ch[$];
    logic [NCH-1:0] pend, clrv;
    logic [W-1:0] words [NCH];
    bit seen, stop;
    apply_reset();
    for (int c = 0; c < NCH; c++) begin hist[c] = 0; hlen[c] = 0; end
    rr_m = 0;
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        clrv = NCH'($urandom_range(1, 15));
        clr = clrv;
        @(posedge clk); #1 clr = '0;
        for (int c = 0; c < NCH; c++) if (clrv[c]) begin hist[c] = 0; hlen[c] = 0; end
      end
      pend = NCH'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) begin
        words[c] = W'($urandom);
        data[c*W +: W] = words[c];
      end
      req = pend;
      stop = 1'b0;
      while (pend != '0 && !stop) begin
        n0 = ack_ch_q.size();
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
          @(posedge clk);
          if (ack_ch_q.size() > n0) seen = 1'b1;
        end
        #1;
        if (!seen) begin
          checks++; errors++;
          $display("FAIL rand_timeout round%0d: no ack, pending %b", r, pend);
          stop = 1'b1;
          req = '0;
        end else begin
          got = ack_ch_q[ack_ch_q.size()-1];
          t   = ack_t_q[ack_t_q.size()-1];
          req[got] = 1'b0;
          exp_c = -1;
          for (int i = NCH - 1; i >= 0; i--) if (pend[(rr_m + i) % NCH]) exp_c = (rr_m + i) % NCH;
          checks++;
          if (got != exp_c) begin errors++; $display("FAIL rand_grant round%0d: got ch%0d, expected ch%0d", r, got, exp_c); end
          pend[got] = 1'b0;
          for (int k = 0; k < W; k++) begin
            hist[got] = ((hist[got] << 1) | int'(words[got][W-1-k])) & 7;
            hlen[got]++;
            if (hlen[got] >= 3 && hist[got] == 5) begin
              exp_t.push_back(t + k + 2);
              exp_ch.push_back(got);
            end
          end
          rr_m = (got + 1) % NCH;
        end
      end
      wait_idle();
    end
    checks++;
    if (m_t_q.size() != exp_t.size()) begin
      errors++; $display("FAIL rand_match_count: got %0d, expected %0d", m_t_q.size(), exp_t.size());
    end
    for (int i = 0; i < m_t_q.size() && i < exp_t.size(); i++) begin
      checks++;
      if (m_t_q[i] != exp_t[i] || m_ch_q[i] != exp_ch[i]) begin
        errors++;
        $display("FAIL rand_match%0d: got cycle %0d ch%0d, expected cycle %0d ch%0d", i, m_t_q[i], m_ch_q[i], exp_t[i], exp_ch[i]);
      end
    end
    checks++;
    if (int'(match_cnt) != exp_t.size()) begin
      errors++; $display("FAIL rand_match_cnt: got %0d, expected %0d", match_cnt, exp_t.size());
    end
    checks++;
    if (ack_bad != 0) begin errors++; $display("FAIL rand_ack_onehot: got %0d bad cycles, expected 0", ack_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cross_word();
    test_isolation();
    test_round_robin();
    test_clear();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_arbiter.md
SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels; SHALL be fixed at 4 for this release.
REQ-002 Parameter W, default 8, bits per request word.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NCH  per-channel request; SHALL be held with stable data until ack.
REQ-006 data  input  NCH*W  channel c word at bits [c*W +: W].
REQ-007 clr  input  NCH  per-channel pulse that clears the saved detector context.
REQ-008 ack  output  NCH  one-hot, one-cycle pulse when a channel's word is accepted.
REQ-009 match  output  1  one-cycle pulse per detected "101", overlapped.
REQ-010 match_ch  output  2  channel owning the current match pulse; valid only with match.
REQ-011 match_cnt  output  16  total matches since reset; saturates at 16'hFFFF.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL time-share one "101" Moore overlapped detector core among NCH serial channels, one W-bit word per grant.
REQ-014 Controller FSM states: IDLE, SHIFT, STORE.
REQ-015 In IDLE, if any req is high, the block SHALL grant the first requesting channel at or after rr_ptr (round-robin):
- pulse ack for that channel
- latch the word and channel id
- load that channel's saved 2-bit context into the core
- go to SHIFT.
REQ-016 In IDLE with no req, the FSM SHALL stay in IDLE and ack SHALL be 0.
REQ-017 SHIFT SHALL last exactly W cycles, feeding one bit per cycle MSB first into the core.
REQ-018 After SHIFT, the FSM SHALL spend one cycle in STORE, write the core state back to the granted channel's context, set rr_ptr to granted+1 mod NCH, and return to IDLE.
REQ-019 Service period SHALL be exactly W+2 cycles per word. Earliest next ack is the cycle after STORE.
REQ-020 Core states and transitions (next state for input 0 / 1):
- S0: S0 / S1
- S1: S2 / S1
- S2: S0 / S3
- S3: S2 / S1.
REQ-021 Core output SHALL be 1 iff the state is S3 (Moore), giving one-cycle latency from the completing bit.
REQ-022 match SHALL be asserted in the cycle after each bit that moves the core into S3; the last bit's match falls in STORE.
REQ-023 Context SHALL persist per channel across words, so patterns spanning word boundaries of the same channel are detected; words of other channels SHALL NOT affect it.
REQ-024 clr[c] SHALL set context[c] to S0.
REQ-025 If clr[c] coincides with the STORE write-back for c, the clear SHALL win.
REQ-026 clr for the channel in service SHALL NOT alter the active core, only the stored context.
REQ-027 A req deasserted before ack SHALL simply not be granted. Withdrawing req after ack SHALL have no effect on the word in service.
REQ-028 match_cnt SHALL increment by 1 per match pulse and hold at 16'hFFFF.

Reset
REQ-029 On rst the block SHALL enter IDLE, set all contexts to S0, rr_ptr to 0, core to S0, and ack, match, match_ch, match_cnt and busy to 0.
REQ-030 rst during SHIFT or STORE SHALL abort the word without write-back and without further match pulses.

Structure
REQ-031 A shared package SHALL hold the core state encoding (S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11) and the FSM state encoding (IDLE, SHIFT, STORE).
REQ-032 The detector SHALL be a sub-module seq101_core with ports clk, rst, load, load_state[1:0], in, state[1:0] and out.

Verification
REQ-033 Only ch0 requests, data 8'b1010_1010 -> ack[0] one cycle, busy for 10 cycles, 3 match pulses with match_ch=0, match_cnt=3.
REQ-034 ch1 sends 8'b0000_0010, then 8'b1000_0000 -> 0 matches from word 1, 1 match on the first bit of word 2 (cross-word overlap).
REQ-035 ch1 as REQ-034 word 1, then ch2 sends 8'b1000_0000, then ch1 sends 8'b1000_0000 -> ch2 gives no match; ch1's second word gives 1 match (context isolation).
REQ-036 All four req high continuously -> ack order 0,1,2,3,0 with acks spaced exactly 10 cycles apart.
REQ-037 clr[1] pulsed in ch1's STORE cycle after word 8'b0000_0010, then 8'b1000_0000 -> no match (clear wins).
REQ-038 rst asserted mid-SHIFT, then ch0 sends 8'b1000_0000 -> no match, match_cnt=0, rr_ptr restarts at ch0.
